// File: rtl/hls_bus_pkg.sv
// Shared types and constants for the HLS ap_bus responder.
package hls_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } bus_state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/bus_resp_mem.sv
// Word memory behind the responder: synchronous write, combinational read.
// Contents are not reset, so data written before a reset survives it.
module bus_resp_mem #(
  parameter int DATA_W    = 128,
  parameter int MEM_DEPTH = 256,
  parameter int PTR_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hls_bus_responder.sv
// Memory-side end of the HLS ap_bus req/rsp interface: accepts read/write
// bursts, stores write beats, returns read words through a one-entry register.
module hls_bus_responder
  import hls_bus_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int SIZE_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              req_din,
  input  logic              req_write,
  output logic              req_full_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [SIZE_W-1:0] size,
  input  logic [DATA_W-1:0] dataout,
  output logic              rsp_empty_n,
  input  logic              rsp_read,
  output logic              rsp_dout,
  output logic [DATA_W-1:0] datain,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(MEM_DEPTH - 1);

  // Handshake: a request/beat transfers on a rising edge with req_write && req_full_n;
  // a response word transfers on a rising edge with rsp_read && rsp_empty_n.

  bus_state_t        state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [SIZE_W-1:0] cnt, cnt_nxt;
  logic              wrap, wrap_nxt;
  logic              err_nxt;
  logic              accept, rsp_pop, rsp_load;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [PTR_W-1:0]  addr_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_addr_bits;

  assign addr_idx         = address[PTR_W-1:0];
  assign unused_addr_bits = ^address[ADDR_W-1:PTR_W];

  assign req_full_n = (state != RD);
  assign busy       = (state != IDLE);
  assign accept     = req_write && req_full_n;
  assign rsp_pop    = rsp_read && rsp_empty_n;
  // Refill the response register when it is empty or being drained this cycle.
  assign rsp_load   = (state == RD) && (cnt != '0) && (!rsp_empty_n || rsp_read);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    wrap_nxt  = wrap;
    err_nxt   = err;
    mem_we    = 1'b0;
    mem_waddr = ptr;
    case (state)
      IDLE: begin
        if (accept && (size != '0)) begin
          wrap_nxt = 1'b0;
          if (req_din == REQ_READ) begin
            ptr_nxt   = addr_idx;
            cnt_nxt   = size;
            state_nxt = RD;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = addr_idx;
            ptr_nxt   = addr_idx + PTR_W'(1);
            cnt_nxt   = size - SIZE_W'(1);
            if (size != SIZE_W'(1)) begin
              state_nxt = WR;
            end
          end
        end
      end
      RD: begin
        if (rsp_load) begin
          ptr_nxt = ptr + PTR_W'(1);
          cnt_nxt = cnt - SIZE_W'(1);
          if (ptr == PTR_MAX) begin
            wrap_nxt = 1'b1;
          end
        end else if (rsp_pop && (cnt == '0)) begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        if (accept) begin
          if (req_din == REQ_WRITE) begin
            mem_we  = 1'b1;
            ptr_nxt = ptr + PTR_W'(1);
            cnt_nxt = cnt - SIZE_W'(1);
            if (cnt == SIZE_W'(1)) begin
              state_nxt = IDLE;
            end
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      wrap        <= 1'b0;
      err         <= 1'b0;
      rsp_empty_n <= 1'b0;
      rsp_dout    <= 1'b0;
      datain      <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      wrap  <= wrap_nxt;
      err   <= err_nxt;
      if (rsp_load) begin
        datain      <= mem_rdata;
        rsp_dout    <= wrap;
        rsp_empty_n <= 1'b1;
      end else if (rsp_pop) begin
        rsp_empty_n <= 1'b0;
      end
    end
  end

  bus_resp_mem #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH),
    .PTR_W    (PTR_W)
  ) u_mem (
    .clk  (ap_clk),
    .we   (mem_we && !ap_rst),
    .waddr(mem_waddr),
    .wdata(dataout),
    .raddr(ptr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_hls_bus_responder.sv
// Directed bench for hls_bus_responder: a memory/queue model predicts every
// response word; a negedge compare process checks the DUT against it.
module tb_hls_bus_responder;
  import hls_bus_pkg::*;

  localparam int DW = 128;
  localparam int MD = 16;

  localparam logic [DW-1:0] WA = 128'hAAAA_0001_1111_2222_3333_4444_5555_6666;
  localparam logic [DW-1:0] WB = 128'hBBBB_0002_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [DW-1:0] WC = 128'hCCCC_0003_DDDD_EEEE_FFFF_0000_1234_5678;
  localparam logic [DW-1:0] WD = 128'hDDDD_0004_0BAD_F00D_CAFE_BABE_0000_0007;
  localparam logic [DW-1:0] WX = 128'h5A5A_0015_0000_0000_0000_0000_0000_000F;
  localparam logic [DW-1:0] WY = 128'hA5A5_0016_0000_0000_0000_0000_0000_0000;
  localparam logic [DW-1:0] WP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] WQ = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          req_din;
  logic          req_write;
  logic          req_full_n;
  logic [31:0]   address;
  logic [31:0]   size;
  logic [DW-1:0] dataout;
  logic          rsp_empty_n;
  logic          rsp_read;
  logic          rsp_dout;
  logic [DW-1:0] datain;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  logic run_cmp = 1'b0;

  logic [DW-1:0] mdl_mem [MD];
  logic          mdl_err = 1'b0;
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] wbuf [8];

  always #5 ap_clk = ~ap_clk;

  hls_bus_responder #(
    .DATA_W(DW), .ADDR_W(32), .SIZE_W(32), .MEM_DEPTH(MD)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_din(req_din), .req_write(req_write),
    .req_full_n(req_full_n), .address(address), .size(size), .dataout(dataout),
    .rsp_empty_n(rsp_empty_n), .rsp_read(rsp_read), .rsp_dout(rsp_dout),
    .datain(datain), .busy(busy), .err(err)
  );

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every visible response word must be the head of the expected queue.
  always @(negedge ap_clk) begin
    if (run_cmp) begin
      chk_bit("err_flag", err, mdl_err);
      if (rsp_empty_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_word: got %h expected no word", {rsp_dout, datain});
        end else begin
          chk_word("rsp_word", {rsp_dout, datain}, exp_q[0]);
          if (rsp_read) void'(exp_q.pop_front());
        end
      end
      if (ap_rst) exp_q.delete();
    end
  end

  task automatic push_expected(input logic [31:0] addr, input int sz);
    int base;
    base = int'(addr % 32'd16);
    for (int i = 0; i < sz; i++) begin
      exp_q.push_back({((base + i) >= MD), mdl_mem[(base + i) % MD]});
    end
  endtask

  // Drives nbeats write beats; beat index bad (if >= 0) carries req_din=0.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] sz, input int nbeats, input int bad);
    int  base;
    logic abort;
    base  = int'(addr % 32'd16);
    abort = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge ap_clk); #1;
      chk_bit("wr_full_n", req_full_n, 1'b1);
      req_write = 1'b1;
      req_din   = (i == bad) ? REQ_READ : REQ_WRITE;
      dataout   = wbuf[i];
      address   = (i == 0) ? addr : $urandom;
      size      = (i == 0) ? sz : $urandom;
      if (i == bad) abort = 1'b1;
      else if (i < int'(sz)) mdl_mem[(base + i) % MD] = wbuf[i];
    end
    @(posedge ap_clk); #1;
    req_write = 1'b0;
    if (abort) mdl_err = 1'b1;
    @(negedge ap_clk);
    chk_bit("wr_done_busy", busy, 1'b0);
    chk_bit("wr_done_full_n", req_full_n, 1'b1);
  endtask

  // Read burst; the master holds rsp_read low for the first stall cycles a word is visible.
  task automatic do_read(input logic [31:0] addr, input int sz, input int stall);
    int cyc;
    int seen;
    push_expected(addr, sz);
    @(posedge ap_clk); #1;
    req_write = 1'b1;
    req_din   = REQ_READ;
    address   = addr;
    size      = sz;
    rsp_read  = (stall == 0);
    @(posedge ap_clk); #1;
    req_write = 1'b0;
    address   = $urandom;
    size      = $urandom;
    @(negedge ap_clk);
    chk_bit("rd_accept_empty_n", rsp_empty_n, 1'b0);
    chk_bit("rd_accept_full_n", req_full_n, !(sz > 0));
    chk_bit("rd_accept_busy", busy, (sz > 0));
    cyc  = 0;
    seen = 0;
    while (exp_q.size() != 0 && cyc < 64) begin
      @(posedge ap_clk); #1;
      cyc++;
      if (cyc == 1) chk_bit("rd_first_word", rsp_empty_n, 1'b1);
      if (rsp_empty_n) seen++;
      rsp_read = (seen > stall);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    rsp_read = 1'b0;
    @(negedge ap_clk);
    chk_bit("rd_done_empty_n", rsp_empty_n, 1'b0);
    chk_bit("rd_done_full_n", req_full_n, 1'b1);
    chk_bit("rd_done_busy", busy, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge ap_clk); #1;
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst  = 1'b0;
    mdl_err = 1'b0;
    chk_bit("rst_empty_n", rsp_empty_n, 1'b0);
    chk_bit("rst_full_n", req_full_n, 1'b1);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_err", err, 1'b0);
    chk_bit("rst_rsp_dout", rsp_dout, 1'b0);
    chk_word("rst_datain", {1'b0, datain}, '0);
  endtask

  initial begin
    ap_rst = 1'b1; req_din = 1'b0; req_write = 1'b0; address = '0;
    size = '0; dataout = '0; rsp_read = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk_bit("reset_full_n", req_full_n, 1'b1);
    chk_bit("reset_empty_n", rsp_empty_n, 1'b0);
    chk_bit("reset_rsp_dout", rsp_dout, 1'b0);
    chk_word("reset_datain", {1'b0, datain}, '0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_err", err, 1'b0);
    ap_rst  = 1'b0;
    run_cmp = 1'b1;

    // Write A,B,C at 4, then read them back at full rate with literal expectations.
    wbuf[0] = WA; wbuf[1] = WB; wbuf[2] = WC;
    do_write(32'd4, 32'd3, 3, -1);
    push_expected(32'd4, 3);
    @(posedge ap_clk); #1;
    req_write = 1'b1; req_din = REQ_READ; address = 32'd4; size = 32'd3; rsp_read = 1'b1;
    @(posedge ap_clk); #1;
    req_write = 1'b0;
    chk_bit("t1_wait_empty_n", rsp_empty_n, 1'b0);
    chk_bit("t1_wait_full_n", req_full_n, 1'b0);
    @(posedge ap_clk); #1;
    chk_bit("t1_w0_valid", rsp_empty_n, 1'b1);
    chk_word("t1_w0", {rsp_dout, datain}, {1'b0, WA});
    @(posedge ap_clk); #1;
    chk_word("t1_w1", {rsp_dout, datain}, {1'b0, WB});
    @(posedge ap_clk); #1;
    chk_word("t1_w2", {rsp_dout, datain}, {1'b0, WC});
    @(posedge ap_clk); #1;
    rsp_read = 1'b0;
    chk_bit("t1_end_empty_n", rsp_empty_n, 1'b0);
    chk_bit("t1_end_full_n", req_full_n, 1'b1);
    chk_bit("t1_end_busy", busy, 1'b0);

    // Backpressure: word held for 5 cycles, then A,B,C in order.
    do_read(32'd4, 3, 5);

    // Wrap at the top of a 16-word memory; upper address bits ignored.
    wbuf[0] = WX; wbuf[1] = WY;
    do_write(32'd15, 32'd2, 2, -1);
    push_expected(32'hABC0_001F, 2);
    @(posedge ap_clk); #1;
    req_write = 1'b1; req_din = REQ_READ; address = 32'hABC0_001F; size = 32'd2; rsp_read = 1'b1;
    @(posedge ap_clk); #1;
    req_write = 1'b0;
    @(posedge ap_clk); #1;
    chk_word("t3_x", {rsp_dout, datain}, {1'b0, WX});
    @(posedge ap_clk); #1;
    chk_word("t3_y", {rsp_dout, datain}, {1'b1, WY});
    @(posedge ap_clk); #1;
    rsp_read = 1'b0;
    chk_bit("t3_end_empty_n", rsp_empty_n, 1'b0);

    // Longer burst across the wrap with a short stall.
    wbuf[0] = WQ; wbuf[1] = WP; wbuf[2] = WD; wbuf[3] = WC;
    do_write(32'h0000_F00E, 32'd4, 4, -1);
    do_read(32'd14, 4, 2);

    // Zero-length read and write do nothing.
    do_read(32'd9, 0, 0);
    wbuf[0] = WP;
    do_write(32'd4, 32'd0, 1, -1);
    do_read(32'd4, 3, 0);

    // Reset after one of four words popped.
    wbuf[0] = WD;
    do_write(32'd7, 32'd1, 1, -1);
    push_expected(32'd4, 4);
    @(posedge ap_clk); #1;
    req_write = 1'b1; req_din = REQ_READ; address = 32'd4; size = 32'd4; rsp_read = 1'b0;
    @(posedge ap_clk); #1;
    req_write = 1'b0;
    @(posedge ap_clk); #1;
    chk_bit("t5_first_valid", rsp_empty_n, 1'b1);
    rsp_read = 1'b1;
    @(posedge ap_clk); #1;
    rsp_read = 1'b0;
    chk_word("t5_second_word", {rsp_dout, datain}, {1'b0, WB});
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    chk_bit("t5_rst_empty_n", rsp_empty_n, 1'b0);
    chk_bit("t5_rst_full_n", req_full_n, 1'b1);
    chk_bit("t5_rst_busy", busy, 1'b0);
    do_read(32'd4, 4, 1);

    // Aborted write burst: err sticky, mem[5] keeps B.
    wbuf[0] = WP; wbuf[1] = WQ;
    do_write(32'd4, 32'd3, 2, 1);
    chk_bit("t6_err", err, 1'b1);
    chk_word("t6_model_mem5", {1'b0, mdl_mem[5]}, {1'b0, WB});
    do_read(32'd4, 2, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    chk_bit("t6_err_sticky", err, 1'b1);
    pulse_reset();

    repeat (2) @(posedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
